// File: rtl/mem_io_bridge_pkg.sv
// mem_io_bridge_pkg: shared FSM state type and constants for the memory/I-O bridge
package mem_io_bridge_pkg;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP, HOLD} bridge_state_t;
    localparam logic [15:0] IO_ADDR_DEFAULT  = 16'hFFFF;
    localparam int          MAX_READ_LATENCY = 4;
endpackage

// File: rtl/mem_io_bridge_sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous level inputs
module sync_2ff #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, meta} <= '0;
        else        {q, meta} <= {meta, d};
endmodule

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: SLC-3 core to BRAM / memory-mapped I-O bridge; optional MEM_IO_BRIDGE_RANGE_CHECK_EN
module mem_io_bridge
    import mem_io_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 10,
    parameter int          READ_LATENCY = 2,
    parameter logic [15:0] IO_ADDR      = IO_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_mem_ena,
    input  logic                  mem_wr_ena,
    input  logic [15:0]           mem_addr,
    input  logic [15:0]           mem_wdata,
    output logic [15:0]           mem_rdata,
    output logic                  mem_ready,
    input  logic [15:0]           sw_i,
    output logic [15:0]           hex_o,
    output logic                  err_o,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [15:0]           bram_wdata,
    input  logic [15:0]           bram_rdata
);
    localparam int CW = $clog2(MAX_READ_LATENCY + 1);
    bridge_state_t  state;
    logic [CW-1:0]  cnt;
    logic           req_io, req_oor, accept, is_io, oor;
    logic [15:0]    sw_sync;
    sync_2ff #(.WIDTH(16)) u_sw_sync (.clk(clk), .reset(reset), .d(sw_i), .q(sw_sync));
    assign accept = state == IDLE && mem_mem_ena;
    assign is_io  = mem_addr == IO_ADDR;
`ifdef MEM_IO_BRIDGE_RANGE_CHECK_EN
    assign oor = !is_io && |(mem_addr >> ADDR_WIDTH);
    always_ff @(posedge clk or negedge reset)
        if (!reset)             err_o <= 1'b0;
        else if (accept && oor) err_o <= 1'b1;
`else
    assign oor   = 1'b0;
    assign err_o = 1'b0;
`endif
    // reset gates the strobes so a mid-access reset kills them at once
    assign bram_en    = reset && accept && !is_io && !oor;
    assign bram_we    = bram_en && mem_wr_ena;
    assign bram_addr  = mem_addr[ADDR_WIDTH-1:0];
    assign bram_wdata = mem_wdata;
    assign mem_ready  = state == RESP;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_io    <= 1'b0;
            req_oor   <= 1'b0;
            mem_rdata <= '0;
            hex_o     <= '0;
        end else begin
            unique case (state)
                IDLE: if (mem_mem_ena) begin
                    req_io  <= is_io;
                    req_oor <= oor;
                    if (mem_wr_ena) begin
                        if (is_io) hex_o <= mem_wdata;
                        state <= RESP;
                    end else begin
                        cnt   <= CW'(READ_LATENCY);
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        mem_rdata <= req_io ? sw_sync : req_oor ? 16'h0000 : bram_rdata;
                        state     <= RESP;
                    end
                end
                RESP:    state <= mem_mem_ena ? HOLD : IDLE;
                HOLD:    if (!mem_mem_ena) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// tb_mem_io_bridge: vector table, corner sequences and randomized accesses against a behavioural model
module tb_mem_io_bridge;
    logic        clk = 0, reset = 0;
    logic        mem_mem_ena = 0, mem_wr_ena = 0;
    logic [15:0] mem_addr = 0, mem_wdata = 0, sw_i = 0;
    logic [15:0] mem_rdata, hex_o, bram_wdata, bram_rdata;
    logic        mem_ready, err_o, bram_en, bram_we;
    logic [9:0]  bram_addr;
    int          total = 0, bad = 0;

    mem_io_bridge dut (
        .clk(clk), .reset(reset), .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sw_i(sw_i), .hex_o(hex_o), .err_o(err_o), .bram_en(bram_en), .bram_we(bram_we),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
    );

    always #5 clk = ~clk;

    // external 1024x16 BRAM with two-cycle read latency
    logic [15:0] bram [1024];
    logic [15:0] p0 = 0, p1 = 0;
    assign bram_rdata = p1;
    always @(posedge clk) begin
        if (bram_en && bram_we) bram[bram_addr] <= bram_wdata;
        if (bram_en && !bram_we) p0 <= bram[bram_addr];
        p1 <= p0;
    end

`ifdef MEM_IO_BRIDGE_RANGE_CHECK_EN
    localparam bit RC = 1;
`else
    localparam bit RC = 0;
`endif

    logic [15:0] ref_mem [1024];
    logic [15:0] ref_hex = 0, ref_rdata = 0;
    logic        ref_err = 0;

    function automatic bit out_of_range(input logic [15:0] a);
        return RC && a != 16'hFFFF && a >= 16'd1024;
    endfunction

    task automatic model(input logic wr, input logic [15:0] a, d);
        bit o = out_of_range(a);
        if (o) ref_err = 1;
        if (wr) begin
            if (a == 16'hFFFF) ref_hex = d;
            else if (!o) ref_mem[a % 1024] = d;
        end else
            ref_rdata = a == 16'hFFFF ? sw_i : o ? 16'h0000 : ref_mem[a % 1024];
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input logic wr, input logic [15:0] a, d,
                          output int lat, output logic en_seen, we_seen);
        @(negedge clk);
        mem_wr_ena = wr; mem_addr = a; mem_wdata = d; mem_mem_ena = 1;
        #1;
        en_seen = bram_en; we_seen = bram_we;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_ready) begin lat = k; break; end
        end
        mem_mem_ena = 0;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr, wdata, sw, exp_rdata, exp_hex;
        int          exp_lat;
        logic        exp_en, exp_we;
    } vec_t;
    vec_t tbl [9];

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat, n;
        logic en_s, we_s;
        for (int i = 0; i < 1024; i++) begin bram[i] = 0; ref_mem[i] = 0; end
        tbl[0] = '{1, 16'h0005, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1};
        tbl[1] = '{0, 16'h0005, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 3, 1, 0};
        tbl[2] = '{1, 16'hFFFF, 16'hBEEF, 16'h0000, 16'h1234, 16'hBEEF, 1, 0, 0};
        tbl[3] = '{0, 16'hFFFF, 16'h0000, 16'h00A5, 16'h00A5, 16'hBEEF, 3, 0, 0};
        tbl[4] = '{1, 16'h0010, 16'hCAFE, 16'h00A5, 16'h00A5, 16'hBEEF, 1, 1, 1};
        tbl[5] = '{0, 16'h0010, 16'h0000, 16'h3C3C, 16'hCAFE, 16'hBEEF, 3, 1, 0};
        tbl[6] = '{0, 16'h0405, 16'h0000, 16'h3C3C, RC ? 16'h0000 : 16'h1234, 16'hBEEF, 3, !RC, 0};
        tbl[7] = '{1, 16'h03FF, 16'h5A5A, 16'h3C3C, tbl[6].exp_rdata, 16'hBEEF, 1, 1, 1};
        tbl[8] = '{0, 16'h03FF, 16'h0000, 16'h3C3C, 16'h5A5A, 16'hBEEF, 3, 1, 0};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_rdata", mem_rdata, 0);
        chk("reset_ready", mem_ready, 0);
        chk("reset_hex", hex_o, 0);
        chk("reset_err", err_o, 0);
        reset = 1;

        for (int i = 0; i < 9; i++) begin
            sw_i = tbl[i].sw;
            repeat (3) @(negedge clk);
            access(tbl[i].wr, tbl[i].addr, tbl[i].wdata, lat, en_s, we_s);
            model(tbl[i].wr, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("vec%0d_rdata", i), mem_rdata, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_hex", i), hex_o, tbl[i].exp_hex);
            chk($sformatf("vec%0d_en", i), en_s, tbl[i].exp_en);
            chk($sformatf("vec%0d_we", i), we_s, tbl[i].exp_we);
        end
        chk("err_after_0405", err_o, RC);

        // strobe held for 8 cycles: one pulse, no re-acceptance
        @(negedge clk);
        mem_wr_ena = 0; mem_addr = 16'h0010; mem_mem_ena = 1;
        n = 0;
        repeat (8) begin @(negedge clk); if (mem_ready) n++; end
        chk("hold_pulses", n, 1);
        chk("hold_no_reaccept", bram_en, 0);
        chk("hold_rdata", mem_rdata, 16'hCAFE);
        mem_mem_ena = 0;
        @(negedge clk);

        // strobe dropped during RD_WAIT still completes
        @(negedge clk);
        mem_addr = 16'h03FF; mem_mem_ena = 1;
        @(negedge clk);
        mem_mem_ena = 0;
        n = 0;
        repeat (6) begin @(negedge clk); if (mem_ready) n++; end
        chk("drop_pulses", n, 1);
        chk("drop_rdata", mem_rdata, 16'h5A5A);

        // reset mid-read with strobe still high; re-accepted on first clock after release
        @(negedge clk);
        mem_wr_ena = 0; mem_addr = 16'h0005; mem_mem_ena = 1;
        @(negedge clk);
        #2 reset = 0;
        #1;
        chk("midrst_rdata", mem_rdata, 0);
        chk("midrst_ready", mem_ready, 0);
        chk("midrst_hex", hex_o, 0);
        chk("midrst_err", err_o, 0);
        chk("midrst_en", bram_en, 0);
        chk("midrst_we", bram_we, 0);
        ref_hex = 0; ref_rdata = 0; ref_err = 0;
        @(negedge clk);
        reset = 1;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mem_ready) begin lat = k; break; end
        end
        mem_mem_ena = 0;
        chk("postrst_lat", lat, 3);
        chk("postrst_rdata", mem_rdata, 16'h1234);
        ref_rdata = 16'h1234;

        for (int i = 0; i < 150; i++) begin
            logic        wr;
            logic [15:0] a, d;
            int          sel;
            sw_i = 16'($urandom);
            repeat (2) @(negedge clk);
            sel = $urandom_range(0, 3);
            a   = sel == 3 ? 16'hFFFF : sel == 2 ? (16'h0400 << $urandom_range(0, 5)) | 16'($urandom_range(0, 15))
                                     : 16'(sel * 16'h03F0 + $urandom_range(0, 15));
            wr  = 1'($urandom_range(0, 1));
            d   = 16'($urandom);
            model(wr, a, d);
            access(wr, a, d, lat, en_s, we_s);
            chk($sformatf("rnd%0d_lat", i), lat, wr ? 1 : 3);
            chk($sformatf("rnd%0d_rdata", i), mem_rdata, ref_rdata);
            chk($sformatf("rnd%0d_hex", i), hex_o, ref_hex);
            chk($sformatf("rnd%0d_err", i), err_o, ref_err);
            chk($sformatf("rnd%0d_en", i), en_s, a != 16'hFFFF && !out_of_range(a));
            chk($sformatf("rnd%0d_we", i), we_s, wr && a != 16'hFFFF && !out_of_range(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
